// File: rtl/uart_rx_cfg_module.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1/2 stop bits)
// feeding a circular buffer that a downstream parser can pop up to N words from per cycle.
module uart_rx_cfg_module #(
  parameter int unsigned CLK_MHZ   = 50,
  parameter int unsigned BAUDRATE  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned N         = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             rx,
  output logic [N-1:0][DATA_BITS-1:0]      data,
  input  logic [$clog2(N+1)-1:0]           pop,
  output logic [$clog2(N+1)-1:0]           can_pop,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             overrun
);

  localparam int unsigned SCALE = CLK_MHZ * 1_000_000 / BAUDRATE;
  localparam int unsigned CW    = $clog2(SCALE);
  localparam int unsigned KW    = $clog2(DATA_BITS);
  localparam int unsigned PW    = $clog2(N + 1);
  localparam int unsigned NW    = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [KW-1:0]        bit_k, bit_k_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par_q, par_n;
  logic                 stop_k, stop_k_n;
  logic                 ferr_q, ferr_n;
  logic                 push_c, ferr_c, perr_c, ovr_c;
  logic                 f_c, p_c;
  logic                 push_q;
  logic [DATA_BITS-1:0] word_q;

  logic [DATA_BITS-1:0]          mem [DEPTH];
  logic [AW-1:0]                 rd_ptr, wr_ptr, rd_n, wr_n, idx;
  logic [NW-1:0]                 count, count_n;
  logic [PW-1:0]                 pop_eff, can_pop_n;
  logic [N-1:0][DATA_BITS-1:0]   data_n;
  logic                          full;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int unsigned inc);
    int unsigned s;
    s = 32'(p) + inc;
    return AW'(s % DEPTH);
  endfunction

  assign full = (count == NW'(DEPTH));

  // Frame FSM: next state, bit assembly and commit decision
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_k_n  = bit_k;
    sh_n     = sh;
    par_n    = par_q;
    stop_k_n = stop_k;
    ferr_n   = ferr_q;
    push_c   = 1'b0;
    ferr_c   = 1'b0;
    perr_c   = 1'b0;
    ovr_c    = 1'b0;
    f_c      = 1'b0;
    p_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = CW'(SCALE / 2 - 1);
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            cnt_n   = CW'(SCALE - 1);
            bit_k_n = '0;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          cnt_n = CW'(SCALE - 1);
          if (bit_k == KW'(DATA_BITS - 1)) begin
            state_n  = (PARITY != 0) ? S_PAR : S_STOP;
            stop_k_n = 1'b0;
            ferr_n   = 1'b0;
          end else begin
            bit_k_n = bit_k + KW'(1);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_PAR: begin
        if (cnt == '0) begin
          par_n    = rx_s;
          cnt_n    = CW'(SCALE - 1);
          state_n  = S_STOP;
          stop_k_n = 1'b0;
          ferr_n   = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          cnt_n = CW'(SCALE - 1);
          if (stop_k == 1'(STOP_BITS - 1)) begin
            // commit point: frame error beats parity beats overrun beats push
            f_c     = ferr_q | ~rx_s;
            p_c     = (PARITY != 0) && ((^{sh, par_q}) != (PARITY == 2));
            ferr_c  = f_c;
            perr_c  = !f_c && p_c;
            ovr_c   = !f_c && !p_c && full;
            push_c  = !f_c && !p_c && !full;
            state_n = rx_s ? S_IDLE : S_BREAK;
          end else begin
            ferr_n   = ferr_q | ~rx_s;
            stop_k_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Synchroniser, FSM state and registered result pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_k      <= '0;
      sh         <= '0;
      par_q      <= 1'b0;
      stop_k     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      word_q     <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_k      <= bit_k_n;
      sh         <= sh_n;
      par_q      <= par_n;
      stop_k     <= stop_k_n;
      ferr_q     <= ferr_n;
      push_q     <= push_c;
      if (push_c) word_q <= sh;
      frame_err  <= ferr_c;
      parity_err <= perr_c;
      overrun    <= ovr_c;
    end
  end

  // Buffer next state; an over-sized pop request is dropped entirely
  always_comb begin
    pop_eff   = (pop <= can_pop) ? pop : '0;
    count_n   = count + NW'(push_q) - NW'(pop_eff);
    rd_n      = wrap_add(rd_ptr, 32'(pop_eff));
    wr_n      = push_q ? wrap_add(wr_ptr, 1) : wr_ptr;
    can_pop_n = (count_n > NW'(N)) ? PW'(N) : PW'(count_n);
    data_n    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = wrap_add(rd_n, i);
      if (i < 32'(count_n)) begin
        data_n[i] = (push_q && (idx == wr_ptr)) ? word_q : mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      can_pop <= '0;
      data    <= '0;
    end else begin
      rd_ptr  <= rd_n;
      wr_ptr  <= wr_n;
      count   <= count_n;
      can_pop <= can_pop_n;
      data    <= data_n;
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (rstn && push_q) mem[wr_ptr] <= word_q;
  end

endmodule

// File: tb/tb_uart_rx_cfg_module.sv
// Directed bench for uart_rx_cfg_module: an 8N1 instance and an 8E1 instance, SCALE=10.
module tb_uart_rx_cfg_module;

  localparam int SCALE = 10;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            rx = 1'b1;
  logic            rx_p = 1'b1;
  logic [3:0][7:0] data, data_p;
  logic [2:0]      pop = '0, pop_p = '0;
  logic [2:0]      can_pop, can_pop_p;
  logic            parity_err, frame_err, overrun;
  logic            parity_err_p, frame_err_p, overrun_p;

  int total = 0;
  int bad   = 0;
  int fe_n = 0, pe_n = 0, ov_n = 0;
  int fe_p = 0, pe_p = 0, ov_p = 0;

  uart_rx_cfg_module #(.CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .DEPTH(4), .N(4)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .data(data), .pop(pop), .can_pop(can_pop),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun));

  uart_rx_cfg_module #(.CLK_MHZ(1), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .DEPTH(4), .N(4)) dut_p (
    .clk(clk), .rstn(rstn), .rx(rx_p), .data(data_p), .pop(pop_p), .can_pop(can_pop_p),
    .parity_err(parity_err_p), .frame_err(frame_err_p), .overrun(overrun_p));

  always #5 clk = ~clk;

  // Pulse counters: a pulse wider than one cycle counts more than once
  always @(posedge clk) begin
    #1;
    if (frame_err)    fe_n++;
    if (parity_err)   pe_n++;
    if (overrun)      ov_n++;
    if (frame_err_p)  fe_p++;
    if (parity_err_p) pe_p++;
    if (overrun_p)    ov_p++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input bit to_p, input logic b, input int cyc);
    if (to_p) rx_p = b; else rx = b;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send(input bit to_p, input logic [7:0] v, input bit par_en, input logic par_v,
                      input logic stop_v, input int extra_low);
    drive(to_p, 1'b0, SCALE);
    for (int i = 0; i < 8; i++) drive(to_p, v[i], SCALE);
    if (par_en) drive(to_p, par_v, SCALE);
    drive(to_p, stop_v, SCALE);
    if (extra_low > 0) drive(to_p, 1'b0, extra_low);
    drive(to_p, 1'b1, 12);
  endtask

  task automatic do_pop(input int n);
    pop = 3'(n);
    @(negedge clk);
    pop = '0;
  endtask

  function automatic int tail_or(input logic [3:0][7:0] d, input int cp);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) if (i >= cp) t = t | d[i];
    return int'(t);
  endfunction

  typedef struct {
    int         pop_b;
    logic [7:0] val;
    logic       stop_v;
    int         cp;
    logic [7:0] first;
    logic [7:0] last;
    int         fe;
    int         ov;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{0, 8'hA5, 1'b1, 1, 8'hA5, 8'hA5, 0, 0};
    vt[1] = '{1, 8'h01, 1'b1, 1, 8'h01, 8'h01, 0, 0};
    vt[2] = '{0, 8'h02, 1'b1, 2, 8'h01, 8'h02, 0, 0};
    vt[3] = '{0, 8'h03, 1'b1, 3, 8'h01, 8'h03, 0, 0};
    vt[4] = '{0, 8'h04, 1'b1, 4, 8'h01, 8'h04, 0, 0};
    vt[5] = '{0, 8'h05, 1'b1, 4, 8'h01, 8'h04, 0, 1};
    vt[6] = '{4, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 1, 1};
    vt[7] = '{0, 8'h80, 1'b1, 1, 8'h80, 8'h80, 1, 1};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_can_pop", int'(can_pop), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_pulses", int'({frame_err, parity_err, overrun}), 0);
    chk("rst_can_pop_p", int'(can_pop_p), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Table: single words, fill to overrun, drain, framing error
    for (int r = 0; r < 8; r++) begin
      if (vt[r].pop_b > 0) do_pop(vt[r].pop_b);
      send(1'b0, vt[r].val, 1'b0, 1'b0, vt[r].stop_v, 0);
      chk($sformatf("row%0d_can_pop", r), int'(can_pop), vt[r].cp);
      if (vt[r].cp > 0) begin
        chk($sformatf("row%0d_first", r), int'(data[0]), int'(vt[r].first));
        chk($sformatf("row%0d_last", r), int'(data[vt[r].cp-1]), int'(vt[r].last));
      end
      chk($sformatf("row%0d_tail", r), tail_or(data, vt[r].cp), 0);
      chk($sformatf("row%0d_fe", r), fe_n, vt[r].fe);
      chk($sformatf("row%0d_ov", r), ov_n, vt[r].ov);
    end

    // Start glitch of 3 clocks is rejected, then a normal frame follows
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 50);
    chk("glitch_can_pop", int'(can_pop), 1);
    chk("glitch_pulses", fe_n + pe_n + ov_n, 2);
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    chk("after_glitch_can_pop", int'(can_pop), 2);
    chk("after_glitch_data1", int'(data[1]), 8'h3C);

    // Partial pop and oversized pop
    send(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 0);
    chk("three_can_pop", int'(can_pop), 3);
    do_pop(2);
    chk("pop2_can_pop", int'(can_pop), 1);
    chk("pop2_data0", int'(data[0]), 8'h99);
    chk("pop2_tail", tail_or(data, 1), 0);
    do_pop(3);
    chk("pop3_ignored_can_pop", int'(can_pop), 1);
    chk("pop3_ignored_data0", int'(data[0]), 8'h99);
    do_pop(1);
    chk("pop1_empty", int'(can_pop), 0);

    // Break: stop=0 then line held low 30 bit times
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 30 * SCALE);
    chk("break_fe", fe_n, 2);
    chk("break_no_word", int'(can_pop), 0);
    chk("break_no_other", pe_n + ov_n, 1);
    drive(1'b0, 1'b1, 20);
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    chk("post_break_can_pop", int'(can_pop), 1);
    chk("post_break_data0", int'(data[0]), 8'h3C);

    // Reset in the middle of the data bits
    drive(1'b0, 1'b0, 30);
    rx = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_can_pop", int'(can_pop), 0);
    chk("midrst_data", int'(data), 0);
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0);
    chk("midrst_next_can_pop", int'(can_pop), 1);
    chk("midrst_next_data0", int'(data[0]), 8'h3C);
    chk("midrst_no_pulse", fe_n * 100 + pe_n * 10 + ov_n, 201);

    // Even parity: 0x07 needs parity bit 1
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 0);
    chk("par_bad_pe", pe_p, 1);
    chk("par_bad_can_pop", int'(can_pop_p), 0);
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 0);
    chk("par_good_pe", pe_p, 1);
    chk("par_good_can_pop", int'(can_pop_p), 1);
    chk("par_good_data0", int'(data_p[0]), 8'h07);
    chk("par_other_pulses", fe_p + ov_p, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
